// File: rtl/lif_pkg.sv
// Shared widths, FSM encoding and saturation helper for the spike decoding path.
package lif_pkg;

    localparam int DEF_STATE_W = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_LEN_W   = 8;

    typedef logic [0:0] fsm_t;
    localparam fsm_t S_IDLE = 1'b0;
    localparam fsm_t S_RUN  = 1'b1;

    // All-ones value of a w-bit counter (w in 1..32).
    function automatic logic [31:0] sat_max(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear also drops the sticky overflow flag, load_zero keeps it.
module sat_counter
    import lif_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load_zero,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_plus,
    output logic         at_max,
    output logic         ovf
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        at_max   = (cnt_q == MAX);
        cnt_plus = at_max ? MAX : cnt_q + 1'b1;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load_zero) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_plus;
            ovf_d = ovf_q | at_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns the LIF network spike/membrane outputs into per-window rate and peak,
// plus a free-running inter-spike interval measurement.
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEN_W-1:0]   window_len,
    input  logic               spike_in,
    input  logic [STATE_W-1:0] state_in,
    output logic [CNT_W-1:0]   count_out,
    output logic [STATE_W-1:0] peak_out,
    output logic [CNT_W-1:0]   isi_out,
    output logic               isi_valid,
    output logic               sat_flag,
    output logic               win_valid
);

    fsm_t               state_q, state_d;
    logic [LEN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [STATE_W-1:0] acc_peak_q, acc_peak_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   isi_out_q, isi_out_d;
    logic               isi_valid_q, isi_valid_d;
    logic [CNT_W-1:0]   count_out_q, count_out_d;
    logic [STATE_W-1:0] peak_out_q, peak_out_d;
    logic               sat_flag_q, sat_flag_d;
    logic               win_valid_q, win_valid_d;

    logic               run_en, win_end;
    logic               acc_clear, acc_inc, isi_clear, isi_load0, isi_inc;
    logic [CNT_W-1:0]   acc_cnt, acc_plus, fin_cnt;
    logic               acc_at_max, acc_ovf, fin_sat;
    logic [STATE_W-1:0] fin_peak;
    logic [CNT_W-1:0]   isi_cnt, isi_plus;
    logic               isi_at_max, isi_ovf;
    logic               unused_isi;

    assign unused_isi = ^{isi_cnt, isi_at_max, isi_ovf};

    sat_counter #(.W(CNT_W)) u_acc_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (acc_clear),
        .load_zero (1'b0),
        .inc       (acc_inc),
        .cnt       (acc_cnt),
        .cnt_plus  (acc_plus),
        .at_max    (acc_at_max),
        .ovf       (acc_ovf)
    );

    sat_counter #(.W(CNT_W)) u_isi_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (isi_clear),
        .load_zero (isi_load0),
        .inc       (isi_inc),
        .cnt       (isi_cnt),
        .cnt_plus  (isi_plus),
        .at_max    (isi_at_max),
        .ovf       (isi_ovf)
    );

    always_comb begin
        run_en    = (state_q == S_RUN) && en;
        win_end   = run_en && (win_cnt_q == '0);
        // The last cycle's spike/state must land in the published result
        // even though the accumulators restart on that same edge.
        fin_cnt   = spike_in ? acc_plus : acc_cnt;
        fin_sat   = acc_ovf | (spike_in & acc_at_max);
        fin_peak  = (state_in > acc_peak_q) ? state_in : acc_peak_q;
        acc_clear = !run_en || win_end;
        acc_inc   = run_en && spike_in;
        isi_clear = !run_en;
        isi_load0 = run_en && spike_in;
        isi_inc   = run_en;

        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        acc_peak_d  = acc_peak_q;
        seen_d      = seen_q;
        isi_out_d   = isi_out_q;
        isi_valid_d = isi_valid_q;
        count_out_d = count_out_q;
        peak_out_d  = peak_out_q;
        sat_flag_d  = sat_flag_q;
        win_valid_d = 1'b0;

        if (state_q == S_IDLE) begin
            if (en) begin
                state_d    = S_RUN;
                win_cnt_d  = window_len;
                acc_peak_d = '0;
            end
        end else if (!en) begin
            state_d     = S_IDLE;
            acc_peak_d  = '0;
            seen_d      = 1'b0;
            isi_valid_d = 1'b0;
        end else begin
            if (win_end) begin
                count_out_d = fin_cnt;
                peak_out_d  = fin_peak;
                sat_flag_d  = fin_sat;
                win_valid_d = 1'b1;
                win_cnt_d   = window_len;
                acc_peak_d  = '0;
            end else begin
                win_cnt_d  = win_cnt_q - 1'b1;
                acc_peak_d = fin_peak;
            end
            if (spike_in) begin
                seen_d = 1'b1;
                if (seen_q) begin
                    isi_out_d   = isi_plus;
                    isi_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            win_cnt_q   <= '0;
            acc_peak_q  <= '0;
            seen_q      <= 1'b0;
            isi_out_q   <= '0;
            isi_valid_q <= 1'b0;
            count_out_q <= '0;
            peak_out_q  <= '0;
            sat_flag_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            acc_peak_q  <= acc_peak_d;
            seen_q      <= seen_d;
            isi_out_q   <= isi_out_d;
            isi_valid_q <= isi_valid_d;
            count_out_q <= count_out_d;
            peak_out_q  <= peak_out_d;
            sat_flag_q  <= sat_flag_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign count_out = count_out_q;
    assign peak_out  = peak_out_q;
    assign isi_out   = isi_out_q;
    assign isi_valid = isi_valid_q;
    assign sat_flag  = sat_flag_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: expected window results are queued as stimulus is driven and
// checked when win_valid fires; ISI, abort and reset values are checked inline.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst, en, spike_in;
    logic [7:0] window_len, state_in;
    logic [7:0] count_out, peak_out, isi_out;
    logic       isi_valid, sat_flag, win_valid;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] peak;
        logic       sat;
    } win_t;

    win_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    spike_rate_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .window_len (window_len),
        .spike_in   (spike_in),
        .state_in   (state_in),
        .count_out  (count_out),
        .peak_out   (peak_out),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
        .sat_flag   (sat_flag),
        .win_valid  (win_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        assert (act === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, check the strobe just after it.
    task automatic cyc(input logic e, input logic s, input logic [7:0] st,
                       input logic exp_wv, input string tag);
        en = e;
        spike_in = s;
        state_in = st;
        @(posedge clk);
        #1;
        check({tag, "_win_valid"}, {31'd0, win_valid}, {31'd0, exp_wv});
    endtask

    function automatic win_t mk(input logic [7:0] c, input logic [7:0] p, input logic s);
        win_t w;
        w.cnt  = c;
        w.peak = p;
        w.sat  = s;
        return w;
    endfunction

    always @(negedge clk) begin : monitor
        win_t e;
        if (!rst && win_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_window", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("win_count", {24'd0, count_out}, {24'd0, e.cnt});
                check("win_peak",  {24'd0, peak_out},  {24'd0, e.peak});
                check("win_sat",   {31'd0, sat_flag},  {31'd0, e.sat});
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; spike_in = 1'b0; state_in = 8'd0; window_len = 8'd0;

        // reset, then idle with spikes that must be ignored
        cyc(0, 1, 8'd50, 0, "rst0");
        cyc(0, 0, 8'd60, 0, "rst1");
        rst = 1'b0;
        cyc(0, 1, 8'd70, 0, "idle0");
        cyc(0, 0, 8'd80, 0, "idle1");
        cyc(0, 1, 8'd90, 0, "idle2");
        check("idle_count", {24'd0, count_out}, 32'd0);
        check("idle_peak",  {24'd0, peak_out},  32'd0);
        check("idle_isi",   {24'd0, isi_out},   32'd0);
        check("idle_isi_v", {31'd0, isi_valid}, 32'd0);
        check("idle_sat",   {31'd0, sat_flag},  32'd0);

        // 1-cycle windows
        window_len = 8'd0;
        cyc(1, 0, 8'd0, 0, "w0_load");
        exp_q.push_back(mk(8'd1, 8'd3, 1'b0));
        exp_q.push_back(mk(8'd0, 8'd4, 1'b0));
        exp_q.push_back(mk(8'd1, 8'd5, 1'b0));
        cyc(1, 1, 8'd3, 1, "w0_c0");
        cyc(1, 0, 8'd4, 1, "w0_c1");
        cyc(1, 1, 8'd5, 1, "w0_c2");
        check("w0_isi",   {24'd0, isi_out},   32'd2);
        check("w0_isi_v", {31'd0, isi_valid}, 32'd1);
        cyc(0, 0, 8'd0, 0, "w0_abort");
        check("w0_abort_isi_v", {31'd0, isi_valid}, 32'd0);

        // basic 10-cycle window
        window_len = 8'd9;
        cyc(1, 0, 8'd0, 0, "basic_load");
        exp_q.push_back(mk(8'd3, 8'd90, 1'b0));
        for (int k = 0; k < 10; k++)
            cyc(1, (k == 0 || k == 3 || k == 9), 8'(10 * k), (k == 9), "basic");
        check("basic_count", {24'd0, count_out}, 32'd3);
        check("basic_peak",  {24'd0, peak_out},  32'd90);
        check("basic_isi",   {24'd0, isi_out},   32'd6);
        cyc(0, 0, 8'd0, 0, "basic_abort");

        // back-to-back windows; window_len change lands on the following window
        window_len = 8'd3;
        cyc(1, 0, 8'd0, 0, "b2b_load");
        exp_q.push_back(mk(8'd1, 8'd13, 1'b0));
        exp_q.push_back(mk(8'd1, 8'd23, 1'b0));
        exp_q.push_back(mk(8'd1, 8'd31, 1'b0));
        for (int w = 1; w <= 3; w++) begin
            for (int c = 0; c < ((w == 3) ? 2 : 4); c++) begin
                if (w == 2 && c == 1) window_len = 8'd1;
                cyc(1, (c == 1), 8'(w * 10 + c), (c == ((w == 3) ? 1 : 3)), "b2b");
            end
        end
        cyc(0, 0, 8'd0, 0, "b2b_abort");

        // saturating 256-cycle window, then a light window
        window_len = 8'd255;
        cyc(1, 0, 8'd0, 0, "sat_load");
        window_len = 8'd9;
        exp_q.push_back(mk(8'd255, 8'd255, 1'b1));
        for (int c = 0; c < 256; c++)
            cyc(1, 1, 8'(c), (c == 255), "sat");
        check("sat_count", {24'd0, count_out}, 32'd255);
        check("sat_flag",  {31'd0, sat_flag},  32'd1);
        check("sat_isi",   {24'd0, isi_out},   32'd1);
        exp_q.push_back(mk(8'd2, 8'd7, 1'b0));
        for (int c = 0; c < 10; c++)
            cyc(1, (c == 2 || c == 5), 8'd7, (c == 9), "sat2");
        check("sat2_count", {24'd0, count_out}, 32'd2);
        check("sat2_flag",  {31'd0, sat_flag},  32'd0);
        cyc(0, 0, 8'd0, 0, "sat_abort");

        // ISI across a window boundary, with saturation
        window_len = 8'd255;
        cyc(1, 0, 8'd0, 0, "isi_load");
        exp_q.push_back(mk(8'd2, 8'd0, 1'b0));
        for (int c = 0; c < 310; c++) begin
            cyc(1, (c == 5 || c == 9 || c == 309), 8'd0, (c == 255), "isi");
            if (c == 5) check("isi_first_v", {31'd0, isi_valid}, 32'd0);
            if (c == 9) begin
                check("isi_second", {24'd0, isi_out},   32'd4);
                check("isi_second_v", {31'd0, isi_valid}, 32'd1);
            end
        end
        check("isi_third", {24'd0, isi_out}, 32'd255);
        cyc(0, 0, 8'd0, 0, "isi_abort");

        // abort mid-window, then a fresh window
        window_len = 8'd9;
        cyc(1, 0, 8'd0, 0, "ab_load");
        for (int c = 0; c < 5; c++)
            cyc(1, (c == 1 || c == 2), 8'd200, 0, "ab_run");
        check("ab_pre_isi_v", {31'd0, isi_valid}, 32'd1);
        cyc(0, 0, 8'd0, 0, "ab_c5");
        check("ab_count_hold", {24'd0, count_out}, 32'd2);
        check("ab_peak_hold",  {24'd0, peak_out},  32'd0);
        check("ab_isi_v",      {31'd0, isi_valid}, 32'd0);
        cyc(1, 0, 8'd0, 0, "ab_reload");
        exp_q.push_back(mk(8'd1, 8'd42, 1'b0));
        for (int c = 0; c < 10; c++)
            cyc(1, (c == 0), (c == 3) ? 8'd42 : 8'd0, (c == 9), "ab_fresh");
        check("ab_fresh_count", {24'd0, count_out}, 32'd1);
        cyc(0, 0, 8'd0, 0, "ab_end");

        check("windows_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Downstream consumer of the LIF network outputs: takes the network's output spike and 8-bit membrane state, converts them into per-window rate, inter-spike interval (ISI) and peak-membrane measurements.
- Sits between lif_network and the top-level output pins.
- Windows are programmable, back-to-back, and each window ends with a one-cycle valid strobe.

Parameters:
- STATE_W, 8, width of membrane state input and peak output.
- CNT_W, 8, width of spike count and ISI outputs (both saturating).
- LEN_W, 8, width of window_len input; window length = window_len+1 cycles (1..256).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low aborts/idles the decoder.
- window_len  in  LEN_W  window length minus one; sampled only at window start.
- spike_in  in  1  output spike from lif_network, one cycle per spike.
- state_in  in  STATE_W  membrane state from lif_network, unsigned.
- count_out  out  CNT_W  spikes in last completed window, saturating.
- peak_out  out  STATE_W  max state_in seen in last completed window.
- isi_out  out  CNT_W  most recent inter-spike interval in cycles, saturating.
- isi_valid  out  1  high once at least two spikes have been seen since entering RUN.
- sat_flag  out  1  count for last completed window saturated.
- win_valid  out  1  one-cycle strobe: count_out/peak_out/sat_flag just updated.

Behaviour:
- Reset (rst=1 at clk edge): FSM=IDLE; all outputs 0; internal counters, accumulators and the seen-spike flag cleared. rst has priority over everything.
- FSM states: IDLE, RUN.
- IDLE: spike_in ignored. If en=1: load win_cnt<=window_len, acc_cnt<=0, acc_peak<=0; go to RUN. The first RUN cycle is the cycle after this load.
- RUN, every cycle:
  - if spike_in: acc_cnt<=acc_cnt+1, saturating at 2^CNT_W-1; acc_sat<=1 if the increment would overflow.
  - acc_peak<=max(acc_peak,state_in).
  - win_cnt decrements.
- Window end: the RUN cycle with win_cnt==0 is the last cycle of the window. Its spike and state are included.
- At the end of the window's last cycle (outputs visible in the next cycle):
  - count_out, peak_out and sat_flag are loaded with the final accumulated values.
  - win_valid=1 for exactly one cycle.
- Back-to-back windows: if en=1 on the last cycle, accumulators restart at 0 and win_cnt reloads from window_len that same cycle. There is no gap cycle, so window_len is re-sampled every window.
- If en=0 at any RUN cycle, including the last one: abort to IDLE, no win_valid, count_out/peak_out/sat_flag hold their previous values. Accumulators, the seen-spike flag and isi_valid are cleared.
- ISI (runs independently of window boundaries while in RUN):
  - isi_cnt counts cycles since the last spike, saturating at 2^CNT_W-1.
  - On a spike with seen=1: isi_out<=min(isi_cnt+1, max) and isi_valid<=1. Then isi_cnt<=0 and seen<=1.
  - Example: spikes at RUN cycles 10 and 14 give isi_out=4.
  - Spikes on consecutive cycles give isi_out=1.
- window_len=0 means 1-cycle windows: win_valid is high every cycle while en=1 after the first RUN cycle, and count_out equals that cycle's spike_in.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package lif_pkg:
  - STATE_W, CNT_W, LEN_W defaults.
  - FSM state typedef (IDLE, RUN).
  - the saturation max constant.
- One natural sub-module, sat_counter: parameterised width, with inc, clear and load-zero controls and a saturated flag. Instantiated twice, for acc_cnt and isi_cnt.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, en=0, toggle spike_in -> all outputs 0, no win_valid.
- Basic window: window_len=9, en=1, spikes at RUN cycles 0, 3, 9, state_in ramps 0..90 in steps of 10 -> win_valid once after 10 RUN cycles, count_out=3, peak_out=90, sat_flag=0.
- Back-to-back: window_len=3, en held high, 1 spike per window -> win_valid every 4 cycles with no gap; count_out=1 each window; changing window_len mid-window affects only the next window.
- Saturation: window_len=255, spike_in=1 every cycle -> count_out=255, sat_flag=1. A following window with 2 spikes gives count_out=2 and sat_flag=0.
- ISI: spikes at RUN cycles 5, 9, 309 -> isi_out=4 with isi_valid=1 after 2nd spike; isi_out=255 (saturated) after 3rd.
- Abort: en dropped on cycle 5 of a 10-cycle window -> no win_valid, count_out keeps its prior value, isi_valid=0. Re-raising en starts a fresh window with count_out updating 10 cycles later.
